pipelined_cond_sum_adder: RTL and testbench

PIPELINED_COND_SUM_ADDER -- requirements
Module: pipelined_cond_sum_adder

---
 rtl/csa_pkg.sv | 34 +++
 rtl/csa_merge_cell.sv | 46 ++++
 rtl/pipelined_cond_sum_adder.sv | 194 +++++++++++++++++++
 tb/tb_pipelined_cond_sum_adder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csa_pkg
// Description : Shared definitions for the pipelined conditional-sum adder.
//               Holds the operand-width limits, the per-stage payload record
//               and a gate-level carry helper.
// Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 64;

    // Payload carried by every pipeline stage. At merge level k the group
    // width is 2^k: group j owns sum bits [j*2^k +: 2^k], and its conditional
    // carries and resolved flag sit at index j of the carry/resolved vectors.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum0;      // group sum assuming carry-in 0
        logic [MAX_WIDTH-1:0] sum1;      // group sum assuming carry-in 1
        logic [MAX_WIDTH-1:0] carry0;    // group carry-out assuming carry-in 0
        logic [MAX_WIDTH-1:0] carry1;    // group carry-out assuming carry-in 1
        logic [MAX_WIDTH-1:0] resolved;  // group already uses the real carry-in
        logic                 sub;       // beat is a subtraction
        logic                 a_msb;     // MSB of operand A (x)
        logic                 b_msb;     // MSB of operand B (y or ~y)
    } csa_payload_t;

    // Majority function: carry-out of a single-bit full adder.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_merge_cell.sv
`default_nettype none
// ============================================================================
// Module      : csa_merge_cell
// Description : Combinational conditional-sum merge of two adjacent G-bit
//               groups into one 2G-bit group. The upper group's sum/carry pair
//               is selected by the lower group's conditional carries, or by
//               its real carry once the lower group is resolved.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_merge_cell
    import csa_pkg::*;
#(
    parameter int G = 1
) (
    input  logic [G-1:0]   i_lo_s0,
    input  logic [G-1:0]   i_lo_s1,
    input  logic           i_lo_c0,
    input  logic           i_lo_c1,
    input  logic           i_lo_res,
    input  logic [G-1:0]   i_hi_s0,
    input  logic [G-1:0]   i_hi_s1,
    input  logic           i_hi_c0,
    input  logic           i_hi_c1,
    output logic [2*G-1:0] o_s0,
    output logic [2*G-1:0] o_s1,
    output logic           o_c0,
    output logic           o_c1,
    output logic           o_res
);

    logic w_sel0;
    logic w_sel1;

    // Pick the upper half by the carry the lower half delivers in each case.
    always_comb begin
        w_sel0 = i_lo_c0;
        w_sel1 = i_lo_res ? i_lo_c0 : i_lo_c1;
        o_s0   = {(w_sel0 ? i_hi_s1 : i_hi_s0), i_lo_s0};
        o_s1   = {(w_sel1 ? i_hi_s1 : i_hi_s0), (i_lo_res ? i_lo_s0 : i_lo_s1)};
        o_c0   = w_sel0 ? i_hi_c1 : i_hi_c0;
        o_c1   = w_sel1 ? i_hi_c1 : i_hi_c0;
        o_res  = i_lo_res;
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_cond_sum_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cond_sum_adder
// Description : Pipelined conditional-sum adder/subtractor with valid/ready
//               handshakes. Stage 0 builds per-bit sum/carry pairs, then
//               LEVELS merge levels double the group width; every stage is
//               registered and stalls independently so bubbles collapse.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cond_sum_adder
    import csa_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("pipelined_cond_sum_adder: WIDTH must be a power of two in 4..64");
    end

    // ------------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------------
    logic [LEVELS:0] valid_q;
    logic [LEVELS:0] valid_d;
    csa_payload_t    stage_q [0:LEVELS];
    csa_payload_t    stage_d [0:LEVELS];

    logic [LEVELS:0] w_load;     // stage may capture this cycle
    logic [LEVELS:0] w_in_vld;   // valid bit offered to each stage
    csa_payload_t    w_lvl_in [0:LEVELS];

    // Per-level combinational results, packed by group index
    logic [LEVELS:0][WIDTH-1:0] w_s0;
    logic [LEVELS:0][WIDTH-1:0] w_s1;
    logic [LEVELS:0][WIDTH-1:0] w_c0;
    logic [LEVELS:0][WIDTH-1:0] w_c1;
    logic [LEVELS:0][WIDTH-1:0] w_res;

    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic             w_unused_parity;

    // Subtraction is x + ~y + 1; the caller's carry-in is ignored then.
    assign w_b   = sub ? ~y : y;
    assign w_cin = sub | cin;

    // ------------------------------------------------------------------------
    // Stage 0: per-bit pairs; bit 0 resolves with the effective carry-in
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign w_s0[0][i]  = x[i] ^ w_b[i] ^ w_cin;
            assign w_s1[0][i]  = x[i] ^ w_b[i] ^ w_cin;
            assign w_c0[0][i]  = maj3(x[i], w_b[i], w_cin);
            assign w_c1[0][i]  = maj3(x[i], w_b[i], w_cin);
            assign w_res[0][i] = 1'b1;
        end else begin : g_pair
            assign w_s0[0][i]  = x[i] ^ w_b[i];
            assign w_s1[0][i]  = ~(x[i] ^ w_b[i]);
            assign w_c0[0][i]  = x[i] & w_b[i];
            assign w_c1[0][i]  = x[i] | w_b[i];
            assign w_res[0][i] = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Merge levels: level k pairs the 2^(k-1)-bit groups held by stage k-1
    // ------------------------------------------------------------------------
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int G  = 1 << (k - 1);
        localparam int NG = WIDTH >> k;
        for (genvar j = 0; j < WIDTH; j++) begin : g_grp
            if (j < NG) begin : g_cell
                csa_merge_cell #(
                    .G (G)
                ) u_cell (
                    .i_lo_s0  (stage_q[k-1].sum0[2*j*G +: G]),
                    .i_lo_s1  (stage_q[k-1].sum1[2*j*G +: G]),
                    .i_lo_c0  (stage_q[k-1].carry0[2*j]),
                    .i_lo_c1  (stage_q[k-1].carry1[2*j]),
                    .i_lo_res (stage_q[k-1].resolved[2*j]),
                    .i_hi_s0  (stage_q[k-1].sum0[(2*j+1)*G +: G]),
                    .i_hi_s1  (stage_q[k-1].sum1[(2*j+1)*G +: G]),
                    .i_hi_c0  (stage_q[k-1].carry0[2*j+1]),
                    .i_hi_c1  (stage_q[k-1].carry1[2*j+1]),
                    .o_s0     (w_s0[k][2*j*G +: 2*G]),
                    .o_s1     (w_s1[k][2*j*G +: 2*G]),
                    .o_c0     (w_c0[k][j]),
                    .o_c1     (w_c1[k][j]),
                    .o_res    (w_res[k][j])
                );
            end else begin : g_idle
                assign w_c0[k][j]  = 1'b0;
                assign w_c1[k][j]  = 1'b0;
                assign w_res[k][j] = 1'b0;
            end
        end
    end

    // Pack each level's result into the stage record; sideband bits ride along.
    always_comb begin
        for (int k = 0; k <= LEVELS; k++) begin
            w_lvl_in[k]                       = '0;
            w_lvl_in[k].sum0[WIDTH-1:0]       = w_s0[k];
            w_lvl_in[k].sum1[WIDTH-1:0]       = w_s1[k];
            w_lvl_in[k].carry0[WIDTH-1:0]     = w_c0[k];
            w_lvl_in[k].carry1[WIDTH-1:0]     = w_c1[k];
            w_lvl_in[k].resolved[WIDTH-1:0]   = w_res[k];
            if (k == 0) begin
                w_lvl_in[k].sub   = sub;
                w_lvl_in[k].a_msb = x[WIDTH-1];
                w_lvl_in[k].b_msb = w_b[WIDTH-1];
            end else begin
                w_lvl_in[k].sub   = stage_q[k-1].sub;
                w_lvl_in[k].a_msb = stage_q[k-1].a_msb;
                w_lvl_in[k].b_msb = stage_q[k-1].b_msb;
            end
        end
    end

    // Elastic flow control: a stage loads when empty or when its content moves on.
    always_comb begin
        w_load           = '0;
        w_in_vld         = '0;
        valid_d          = valid_q;
        w_load[LEVELS]   = !valid_q[LEVELS] || out_ready;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            w_load[k] = !valid_q[k] || w_load[k+1];
        end
        for (int k = 0; k <= LEVELS; k++) begin
            w_in_vld[k] = (k == 0) ? in_valid : valid_q[k-1];
            if (w_load[k]) begin
                valid_d[k] = w_in_vld[k];
            end
        end
    end

    // Payload only changes when a real beat arrives, so held outputs stay put.
    always_comb begin
        for (int k = 0; k <= LEVELS; k++) begin
            stage_d[k] = (w_load[k] && w_in_vld[k]) ? w_lvl_in[k] : stage_q[k];
        end
    end

    // Stage registers; reset empties the pipe and clears the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k <= LEVELS; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k <= LEVELS; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Folds payload bits that the narrower levels leave idle.
    always_comb begin
        w_unused_parity = 1'b0;
        for (int k = 0; k <= LEVELS; k++) begin
            w_unused_parity = w_unused_parity ^ (^stage_q[k]);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: the last stage holds one fully resolved WIDTH-bit group
    // ------------------------------------------------------------------------
    assign in_ready  = w_load[0];
    assign out_valid = valid_q[LEVELS];
    assign sum       = stage_q[LEVELS].sum0[WIDTH-1:0];
    assign cout      = stage_q[LEVELS].carry0[0];
    assign ovf       = (stage_q[LEVELS].a_msb == stage_q[LEVELS].b_msb) &&
                       (stage_q[LEVELS].sum0[WIDTH-1] != stage_q[LEVELS].a_msb);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cond_sum_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_cond_sum_adder
// Description : Self-checking bench for pipelined_cond_sum_adder (WIDTH=16):
//               directed vectors with hand-computed results, backpressure,
//               reset with beats in flight and a random soak against a
//               behavioural model. Results are matched in order via a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_cond_sum_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_cond_sum_adder #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] val;   // {ovf, cout, sum}
        int          acc;   // cycle of the input handshake
        bit          lat;   // check the unstalled latency for this beat
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          hold_chk = 1'b0;
    logic [17:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Independent reference: plain arithmetic on the operands.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic s);
        logic [15:0] bb;
        logic [16:0] f;
        logic        o;
        bb = s ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : ci)};
        o  = (a[15] == bb[15]) && (f[15] != a[15]);
        return {o, f[16], f[15:0]};
    endfunction

    // Output monitor: in-order scoreboard, latency and stall-hold checks.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({ovf, cout, sum}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 64'({ovf, cout, sum}), 64'(e.val));
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd5);
                end
            end
            hold_chk = out_valid && !out_ready;
            held     = {ovf, cout, sum};
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic s, input logic [17:0] e, input bit lat);
        int   n;
        exp_t ent;
        x = a; y = b; cin = ci; sub = s; in_valid = 1'b1; n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
        end else begin
            ent.val = e; ent.acc = cyc; ent.lat = lat;
            exp_q.push_back(ent);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [15:0] fx [8] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000,
                            16'h00FF, 16'h0F0F, 16'h7FFF, 16'hFFFE};
    logic [15:0] fy [8] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000,
                            16'h0001, 16'hF0F0, 16'h0001, 16'h0003};
    logic [17:0] fe [8] = '{{2'b00, 16'h0002}, {2'b00, 16'h0020},
                            {2'b00, 16'h0200}, {2'b00, 16'h2000},
                            {2'b00, 16'h0100}, {2'b00, 16'hFFFF},
                            {2'b10, 16'h8000}, {2'b01, 16'h0001}};

    initial begin
        int   acc;
        int   n;
        exp_t ent;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed single beats, {ovf, cout, sum} worked by hand
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}, 1'b1);
        drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 1'b1);
        send(16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 1'b1);
        send(16'h0001, 16'h0002, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0004}, 1'b1);
        send(16'h0005, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0002}, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}, 1'b1);
        drain();

        // Backpressure: eight beats offered with out_ready low
        out_ready = 1'b0; acc = 0; cin = 1'b0; sub = 1'b0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (acc < 8);
            if (acc < 8) begin x = fx[acc]; y = fy[acc]; end
            @(negedge clk);
            if (in_valid && in_ready) begin
                ent.val = fe[acc]; ent.acc = cyc; ent.lat = 1'b0;
                exp_q.push_back(ent);
                acc++;
            end
            @(posedge clk); #1;
        end
        chk("fill_accepted", 64'(acc), 64'd5);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("full_shift_ready", 64'(in_ready), 64'd1);
        n = 0;
        while (acc < 8 && n < 50) begin
            in_valid = 1'b1; x = fx[acc]; y = fy[acc];
            @(negedge clk);
            if (in_ready) begin
                ent.val = fe[acc]; ent.acc = cyc; ent.lat = 1'b0;
                exp_q.push_back(ent);
                acc++;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("fill_all_accepted", 64'(acc), 64'd8);
        drain();

        // Reset with three beats in flight
        out_ready = 1'b0;
        send(16'h1111, 16'h1111, 1'b0, 1'b0, {2'b00, 16'h2222}, 1'b0);
        send(16'h2222, 16'h2222, 1'b0, 1'b0, {2'b00, 16'h4444}, 1'b0);
        send(16'h3333, 16'h3333, 1'b0, 1'b0, {2'b00, 16'h6666}, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_sum", 64'({ovf, cout, sum}), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (8) begin @(posedge clk); #1; end
        send(16'h1234, 16'h4321, 1'b0, 1'b0, {2'b00, 16'h5555}, 1'b1);
        drain();

        // Random soak against the behavioural model
        acc = 0; n = 0;
        while (acc < 10000 && n < 60000) begin
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            x   = 16'($urandom);
            y   = 16'($urandom);
            cin = 1'($urandom_range(1));
            sub = 1'($urandom_range(1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                ent.val = model(x, y, cin, sub); ent.acc = cyc; ent.lat = 1'b0;
                exp_q.push_back(ent);
                acc++;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("random_beats", 64'(acc), 64'd10000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
